icache: RTL and testbench

Direct-mapped instruction cache between the fetch stage and the external instruction memory of `firstCPU`. Fetch presents `pc` each cycle. On a hit, the instruction is returned combinationally in the same cycle. On a miss, the cache stalls the front end and refills the whole line, one word at a time, over a request/ready memory handshake. `stall` drives the PC and IF_ID write enables (`write_PC = write_IFID = !stall`).

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_if.sv | 38 +++
 rtl/icache_store.sv | 58 +++++
 rtl/icache.sv | 131 +++++++++++++
 tb/tb_icache.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icache_pkg;

    // Refill controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int ADDR_W             = 32;
    localparam int WORD_W             = 32;
    localparam int DEF_LINES          = 4;
    localparam int DEF_WORDS_PER_LINE = 4;

    // Tag width left over once the byte, offset and index fields are removed.
    function automatic int tag_width(input int lines, input int words_per_line);
        return ADDR_W - 2 - $clog2(words_per_line) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and instruction-memory-side signals of the instruction cache.
// Latency: n/a (wiring only).
// Backpressure: memReq/memAddr held by the cache until memReady completes a beat.
// Ports: pc/instruction/stall (fetch), memReq/memAddr/memReady/memData (memory).
interface icache_if;
    import icache_pkg::*;

    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] instruction;
    logic              stall;
    logic              memReq;
    logic [ADDR_W-1:0] memAddr;
    logic              memReady;
    logic [WORD_W-1:0] memData;

    // Cache side.
    modport master (
        input  pc,
        output instruction,
        output stall,
        output memReq,
        output memAddr,
        input  memReady,
        input  memData
    );

    // Fetch stage / instruction memory side.
    modport slave (
        output pc,
        input  instruction,
        input  stall,
        input  memReq,
        input  memAddr,
        output memReady,
        output memData
    );

endinterface

// File: rtl/icache_store.sv
// Valid, tag and data arrays of the instruction cache.
// Latency: combinational read port; writes and valid set/clear land on the next edge.
// Backpressure: none; the controller sequences all writes.
// Ports: clock/rst, read port (rd_index/rd_offset -> rd_valid/rd_tag/rd_word),
//        write port (wr_index/wr_offset/wr_word/wr_en, tag_wr/tag_wr_data, valid_set/valid_clr).
module icache_store
    import icache_pkg::*;
#(
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int TAG_W          = tag_width(DEF_LINES, DEF_WORDS_PER_LINE)
) (
    input  logic                              clock,
    input  logic                              rst,
    input  logic [$clog2(LINES)-1:0]          rd_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_offset,
    output logic                              rd_valid,
    output logic [TAG_W-1:0]                  rd_tag,
    output logic [WORD_W-1:0]                 rd_word,
    input  logic [$clog2(LINES)-1:0]          wr_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_offset,
    input  logic [WORD_W-1:0]                 wr_word,
    input  logic                              wr_en,
    input  logic                              tag_wr,
    input  logic [TAG_W-1:0]                  tag_wr_data,
    input  logic                              valid_set,
    input  logic                              valid_clr
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [WORD_W-1:0] data [LINES][WORDS_PER_LINE];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_word  = data[rd_index][rd_offset];

    // Only the valid bits need a reset; tag/data contents are ignored until valid.
    always_ff @(posedge clock) begin
        if (rst) begin
            valid <= '0;
        end else if (valid_clr) begin
            valid[wr_index] <= 1'b0;
        end else if (valid_set) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            data[wr_index][wr_offset] <= wr_word;
        end
        if (tag_wr) begin
            tags[wr_index] <= tag_wr_data;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with whole-line refill.
// Latency: hit returns the word in the same cycle; miss stalls 1 + beat waits + 1 cycles.
// Backpressure: stall freezes fetch; memReq/memAddr held until memReady accepts each beat.
// Ports: clock, rst (sync, active high), bus (icache_if.master: fetch + memory handshake).
module icache
    import icache_pkg::*;
#(
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic     clock,
    input  logic     rst,
    icache_if.master bus
);

    localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
    localparam int INDEX_W  = $clog2(LINES);
    localparam int TAG_W    = tag_width(LINES, WORDS_PER_LINE);
    localparam int LINE_W   = TAG_W + INDEX_W;

    // Address split of the fetch pc; bits [1:0] are byte-within-word.
    logic [OFFSET_W-1:0] pc_offset;
    logic [INDEX_W-1:0]  pc_index;
    logic [TAG_W-1:0]    pc_tag;
    logic                unused_pc_bits;

    assign pc_offset      = bus.pc[2 +: OFFSET_W];
    assign pc_index       = bus.pc[2+OFFSET_W +: INDEX_W];
    assign pc_tag         = bus.pc[ADDR_W-1 -: TAG_W];
    assign unused_pc_bits = ^bus.pc[1:0];

    state_t              state;
    logic [OFFSET_W-1:0] beat;
    logic [OFFSET_W-1:0] beat_next;
    logic [LINE_W-1:0]   line_addr;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;

    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [WORD_W-1:0]   rd_word;
    logic                hit;
    logic                deliver;
    logic                accept;
    logic                beat_last;
    logic [INDEX_W-1:0]  fill_index;
    logic [TAG_W-1:0]    fill_tag;
    logic [INDEX_W-1:0]  store_index;

    assign hit     = rd_valid && (rd_tag == pc_tag);
    assign deliver = hit && (state == ST_IDLE);

    assign bus.instruction = deliver ? rd_word : '0;
    assign bus.stall       = !deliver;
    assign bus.memReq      = mem_req;
    assign bus.memAddr     = mem_addr;

    // The fill always targets the latched line, never the live pc.
    assign fill_index = line_addr[INDEX_W-1:0];
    assign fill_tag   = line_addr[LINE_W-1 -: TAG_W];
    assign beat_next  = beat + OFFSET_W'(1);
    assign beat_last  = (beat == OFFSET_W'(WORDS_PER_LINE - 1));
    assign accept     = (state == ST_REFILL) && mem_req && bus.memReady && !rst;

    // In IDLE the only store write is the valid clear of the missing pc's line.
    assign store_index = (state == ST_IDLE) ? pc_index : fill_index;

    icache_store #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_store (
        .clock       (clock),
        .rst         (rst),
        .rd_index    (pc_index),
        .rd_offset   (pc_offset),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_word     (rd_word),
        .wr_index    (store_index),
        .wr_offset   (beat),
        .wr_word     (bus.memData),
        .wr_en       (accept),
        .tag_wr      (accept && beat_last),
        .tag_wr_data (fill_tag),
        .valid_set   ((state == ST_DONE) && !rst),
        .valid_clr   ((state == ST_IDLE) && !hit && !rst)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= ST_IDLE;
            beat      <= '0;
            line_addr <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!hit) begin
                        line_addr <= {pc_tag, pc_index};
                        beat      <= '0;
                        mem_req   <= 1'b1;
                        mem_addr  <= {pc_tag, pc_index, {OFFSET_W{1'b0}}, 2'b00};
                        state     <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (accept) begin
                        if (beat_last) begin
                            // Drop the request now so DONE never presents a stray beat.
                            mem_req <= 1'b0;
                            state   <= ST_DONE;
                        end else begin
                            beat     <= beat_next;
                            mem_addr <= {line_addr, beat_next, 2'b00};
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetch streams.
// Latency: n/a.
// Backpressure: the bench holds pc while stall is high, as the fetch stage would.
module tb_icache;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    icache_if bus();

    icache #(.LINES(4), .WORDS_PER_LINE(4)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_addr_q[$];

    // Reference model: which tag each line currently holds.
    bit          model_valid [4];
    int unsigned model_tag   [4];

    bit          started    = 0;
    bit          rand_mode  = 0;
    bit          slow_en    = 0;
    bit          slow_watch = 0;
    logic [31:0] slow_addr  = 32'h0;
    int          slow_cnt   = 0;
    int          beat_cnt   = 0;

    // Instruction memory contents: 0xA0 plus the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + {a[31:2], 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            model_valid[i] = 0;
            model_tag[i]   = 0;
        end
    endtask

    // Present a pc; predict hit/miss and queue the expected refill beats and word.
    task automatic issue(input logic [31:0] a, output bit miss);
        int unsigned idx;
        int unsigned tag;
        int unsigned base;
        idx  = (a / 16) % 4;
        tag  = a / 64;
        base = (a / 16) * 16;
        miss = !(model_valid[idx] && model_tag[idx] == tag);
        if (miss) begin
            for (int w = 0; w < 4; w++) exp_addr_q.push_back(base + 4 * w);
            model_valid[idx] = 1;
            model_tag[idx]   = tag;
        end
        exp_instr_q.push_back(mem_word(a));
        bus.pc = a;
    endtask

    // Wait at negedges until the word is delivered; optionally check the stall count.
    task automatic wait_deliver(input string name, input int exp_stall, input bit chk);
        int cycles;
        bit done;
        cycles = 0;
        done   = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clock);
            if (bus.stall === 1'b0) begin
                done = 1;
            end else begin
                cycles++;
                @(posedge clock);
                #1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s timeout: stall still %b after %0d cycles, expected delivery", name, bus.stall, cycles);
        end else if (chk) begin
            check({name, " stall cycles"}, 32'(cycles), 32'(exp_stall));
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int extra, input bit chk);
        bit miss;
        @(posedge clock);
        #1;
        issue(a, miss);
        wait_deliver($sformatf("fetch %h", a), miss ? 6 + extra : 0, chk);
    endtask

    task automatic wait_beats(input int target);
        for (int k = 0; k < 200 && beat_cnt < target; k++) begin
            @(posedge clock);
            #1;
        end
        if (beat_cnt < target) begin
            total++;
            bad++;
            $display("FAIL beat wait: beats=%0d, expected %0d", beat_cnt, target);
        end
    endtask

    // Start a miss on a, switch pc to b while beat 2 is outstanding.
    task automatic redirect(input logic [31:0] a, input logic [31:0] b);
        bit miss;
        int start;
        @(posedge clock);
        #1;
        start = beat_cnt;
        issue(a, miss);
        wait_beats(start + 2);
        exp_instr_q.delete(exp_instr_q.size() - 1);
        issue(b, miss);
        wait_deliver("redirect", 0, 0);
    endtask

    // Start a miss on a, pulse rst during beat 2, then re-fetch a from scratch.
    task automatic reset_mid(input logic [31:0] a);
        bit miss;
        int start;
        @(posedge clock);
        #1;
        start = beat_cnt;
        issue(a, miss);
        wait_beats(start + 2);
        rst = 1'b1;
        exp_instr_q.delete();
        exp_addr_q.delete();
        model_reset();
        @(posedge clock);
        #1;
        rst = 1'b0;
        issue(a, miss);
        @(negedge clock);
        check("memReq after mid-refill reset", 32'(bus.memReq), 32'd0);
        check("memAddr after mid-refill reset", bus.memAddr, 32'h0);
        check("stall after mid-refill reset", 32'(bus.stall), 32'd1);
        @(posedge clock);
        #1;
        wait_deliver("refetch after reset", 5, 1);
    endtask

    // Instruction memory: random or directed wait states per beat.
    int cur_wait = -1;
    bit req_prev = 0;
    initial begin
        bus.memReady = 1'b0;
        bus.memData  = 32'h0;
    end
    always @(posedge clock) begin
        #1;
        if (bus.memReq !== 1'b1) begin
            cur_wait     = -1;
            bus.memReady = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.memData  = $urandom;
        end else begin
            if (req_prev && bus.memReady) cur_wait = -1;
            if (cur_wait < 0) begin
                if (slow_en && bus.memAddr == slow_addr) begin
                    cur_wait = 10;
                    slow_en  = 0;
                end else begin
                    cur_wait = rand_mode ? int'($urandom_range(0, 3)) : 0;
                end
            end
            if (cur_wait == 0) begin
                bus.memReady = 1'b1;
                bus.memData  = mem_word(bus.memAddr);
            end else begin
                bus.memReady = 1'b0;
                bus.memData  = $urandom;
                cur_wait--;
            end
        end
        req_prev = (bus.memReq === 1'b1);
    end

    // Scoreboard monitor: compares delivered words and accepted beat addresses.
    logic        prev_req   = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_addr  = 32'h0;
    always @(negedge clock) begin
        if (started && !rst) begin
            if (bus.stall === 1'b0) begin
                check("memReq low on hit", 32'(bus.memReq), 32'd0);
                if (exp_instr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL instruction: unexpected delivery %h with nothing outstanding", bus.instruction);
                end else begin
                    check("instruction", bus.instruction, exp_instr_q.pop_front());
                end
            end else begin
                check("instruction zero while stalled", bus.instruction, 32'h0);
            end
            if (bus.memReq && bus.memReady) begin
                beat_cnt++;
                if (exp_addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL memAddr: unexpected beat at %h, none expected", bus.memAddr);
                end else begin
                    check("memAddr", bus.memAddr, exp_addr_q.pop_front());
                end
            end
            if (prev_req && !prev_ready && bus.memReq)
                check("memAddr held while waiting", bus.memAddr, prev_addr);
            if (slow_watch && bus.memReq && !bus.memReady && bus.memAddr == slow_addr)
                slow_cnt++;
            prev_req   = bus.memReq;
            prev_ready = bus.memReady;
            prev_addr  = bus.memAddr;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit miss;
        bus.pc = 32'h0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset memReq", 32'(bus.memReq), 32'd0);
        check("reset memAddr", bus.memAddr, 32'h0);
        check("reset stall", 32'(bus.stall), 32'd1);
        check("reset instruction", bus.instruction, 32'h0);

        // Cold miss at 0x0 with zero-wait memory.
        @(posedge clock);
        #1;
        rst     = 1'b0;
        started = 1;
        issue(32'h0, miss);
        wait_deliver("cold miss", 6, 1);

        // Hit stream on the freshly filled line.
        fetch(32'h4, 0, 1);
        fetch(32'h8, 0, 1);
        fetch(32'hC, 0, 1);

        // Conflict eviction on index 0.
        fetch(32'h40, 0, 1);
        fetch(32'h0, 0, 1);

        // Slow memory: 10 wait cycles on beat 1 of line 0.
        fetch(32'h40, 0, 1);
        slow_addr  = 32'h4;
        slow_en    = 1;
        slow_watch = 1;
        slow_cnt   = 0;
        fetch(32'h0, 10, 1);
        slow_watch = 0;
        check("slow beat wait cycles", 32'(slow_cnt), 32'd10);

        // Redirect mid-refill: line 0 still completes, then 0x20 fills.
        fetch(32'h40, 0, 1);
        redirect(32'h0, 32'h20);
        fetch(32'h0, 0, 1);
        fetch(32'h20, 0, 1);

        // Reset mid-refill.
        fetch(32'h40, 0, 1);
        reset_mid(32'h0);

        // Random fetches with random memory waits and ready noise.
        rand_mode = 1;
        for (int i = 0; i < 300; i++) fetch(32'($urandom_range(0, 511)), 0, 0);

        // Random fetches with zero-wait memory; miss penalty checked exactly.
        rand_mode = 0;
        for (int i = 0; i < 200; i++) fetch(32'($urandom_range(0, 511)), 0, 1);

        @(posedge clock);
        #1;
        started = 0;
        check("leftover expected words", 32'(exp_instr_q.size()), 32'd0);
        check("leftover expected beats", 32'(exp_addr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
